// File: rtl/ysyx_24100005_ifu.sv
// Instruction fetch unit: owns the PC, fetches one word per instruction, hands it to the core and records fetch faults.
// Latency: at least 3 cycles per instruction (REQ, WAIT, HOLD); inst_valid rises on the edge that samples the response.
// Backpressure: addr is held until imem_req_ready; inst/inst_pc are held until inst_ready; one request outstanding at most.
module ysyx_24100005_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic [31:0] dnpc,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_FAULT
    } state_t;

    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_RSP_ERR  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;
    // Counter value on the last WAIT cycle allowed before declaring a timeout.
    localparam logic [7:0] WAIT_LAST      = 8'(TIMEOUT - 1);

    state_t      state;
    logic [31:0] pc;
    logic [7:0]  wait_cnt;

    assign imem_req_addr = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            pc             <= RESET_PC;
            wait_cnt       <= 8'd0;
            imem_req_valid <= 1'b0;
            inst_valid     <= 1'b0;
            inst           <= 32'd0;
            inst_pc        <= 32'd0;
            fault          <= 1'b0;
            fault_cause    <= 2'b00;
            fetch_cnt      <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    state          <= S_REQ;
                    imem_req_valid <= 1'b1;
                end
                S_REQ: begin
                    if (imem_req_ready) begin
                        state          <= S_WAIT;
                        imem_req_valid <= 1'b0;
                        wait_cnt       <= 8'd0;
                    end
                end
                S_WAIT: begin
                    // A response arriving on the timeout cycle still counts.
                    if (imem_rsp_valid) begin
                        if (imem_rsp_err) begin
                            state       <= S_FAULT;
                            fault       <= 1'b1;
                            fault_cause <= CAUSE_RSP_ERR;
                        end else begin
                            state      <= S_HOLD;
                            inst       <= imem_rsp_data;
                            inst_pc    <= pc;
                            inst_valid <= 1'b1;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        state       <= S_FAULT;
                        fault       <= 1'b1;
                        fault_cause <= CAUSE_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (inst_ready) begin
                        inst_valid <= 1'b0;
                        fetch_cnt  <= fetch_cnt + 32'd1;
                        pc         <= dnpc;
                        if (dnpc[1:0] != 2'b00) begin
                            state       <= S_FAULT;
                            fault       <= 1'b1;
                            fault_cause <= CAUSE_MISALIGN;
                        end else begin
                            state          <= S_REQ;
                            imem_req_valid <= 1'b1;
                        end
                    end
                end
                S_FAULT: begin
                    state <= S_FAULT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
